// File: rtl/rca_sub_serial_pkg.sv
// rca_sub_serial_pkg: shared FSM state encoding and default operand width
package rca_sub_serial_pkg;
   localparam int WIDTH_DEF = 4;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
endpackage

// File: rtl/rca_sub_serial_if.sv
// rca_sub_serial_if: request/result bundle between a requester and the serial subtractor
interface rca_sub_serial_if import rca_sub_serial_pkg::*; #(parameter int WIDTH = WIDTH_DEF) ();
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             busy;
   logic             done;
   modport master (output start, a, b, bin, input diff, bout, busy, done);
   modport slave  (input start, a, b, bin, output diff, bout, busy, done);
endinterface

// File: rtl/rca_sub_serial_fs_1.sv
// fs_1: one-bit full subtractor, d = x - y - bi with borrow out bo
module fs_1 (
   input  logic x,
   input  logic y,
   input  logic bi,
   output logic d,
   output logic bo
);
   assign d  = x ^ y ^ bi;
   assign bo = (~x & y) | (~(x ^ y) & bi);
endmodule

// File: rtl/rca_sub_serial.sv
// rca_sub_serial: bit-serial ripple subtractor, one bit per clock LSB first,
// with the borrow carried between bits in a flop.
module rca_sub_serial import rca_sub_serial_pkg::*; #(
   parameter int WIDTH = WIDTH_DEF
) (
   input logic             clk,
   input logic             rst_n,
   rca_sub_serial_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);
   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
   logic             brw_q, brw_d, bout_q, bout_d, busy_q, busy_d, done_q, done_d;
   logic             fs_d, fs_bo;
   fs_1 u_fs (.x(a_q[0]), .y(b_q[0]), .bi(brw_q), .d(fs_d), .bo(fs_bo));
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      brw_d   = brw_q;
      diff_d  = diff_q;
      bout_d  = bout_q;
      case (state_q)
         IDLE: if (bus.start) begin
            a_d     = bus.a;
            b_d     = bus.b;
            brw_d   = bus.bin;
            cnt_d   = '0;
            state_d = SHIFT;
         end
         SHIFT: begin
            // operands shift right so the cell always sees bit 0; result fills from the top
            a_d    = a_q >> 1;
            b_d    = b_q >> 1;
            brw_d  = fs_bo;
            diff_d = WIDTH'({fs_d, diff_q} >> 1);
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               bout_d  = fs_bo;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = state_d != IDLE;
      done_d = state_d == DONE;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         brw_q   <= 1'b0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         brw_q   <= brw_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   assign bus.diff = diff_q;
   assign bus.bout = bout_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
endmodule

// File: tb/tb_rca_sub_serial.sv
// tb_rca_sub_serial: directed and exhaustive checks of the serial subtractor at WIDTH=4
module tb_rca_sub_serial;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;
   rca_sub_serial_if #(.WIDTH(4)) bus ();
   rca_sub_serial #(.WIDTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic chk_idle_zero(input string tag);
      chk({tag, ".diff"}, 32'(bus.diff), 0);
      chk({tag, ".bout"}, 32'(bus.bout), 0);
      chk({tag, ".busy"}, 32'(bus.busy), 0);
      chk({tag, ".done"}, 32'(bus.done), 0);
   endtask
   // one operation; rep re-pulses start (a=1,b=1) two edges in
   task automatic op(input string tag, input logic [3:0] a, input logic [3:0] b, input logic bin,
                     input logic [3:0] ed, input logic eb, input bit rep);
      int dn = 0;
      int pos = 0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.a = a;
      bus.b = b;
      bus.bin = bin;
      @(posedge clk);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (bus.done) begin
            dn++;
            pos = k;
         end
         if (k == 1) chk({tag, ".busy1"}, 32'(bus.busy), 1);
         if (k == 1) begin
            bus.start = 1'b0;
            bus.a = ~a;
            bus.b = ~b;
            bus.bin = ~bin;
         end
         if (rep && k == 2) begin
            bus.start = 1'b1;
            bus.a = 4'd1;
            bus.b = 4'd1;
            bus.bin = 1'b0;
         end
         if (k == 3) bus.start = 1'b0;
      end
      chk({tag, ".ndone"}, 32'(dn), 1);
      chk({tag, ".lat"}, 32'(pos), 5);
      chk({tag, ".busy"}, 32'(bus.busy), 0);
      chk({tag, ".diff"}, 32'(bus.diff), 32'(ed));
      chk({tag, ".bout"}, 32'(bus.bout), 32'(eb));
   endtask
   initial begin
      int dn;
      logic [4:0] r;
      bus.start = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.bin = 1'b0;
      #1 chk_idle_zero("rst");
      @(negedge clk);
      rst_n = 1'b1;
      op("ex_3m10", 4'd3, 4'd10, 1'b0, 4'd9, 1'b1, 1'b0);
      op("ex_8m4", 4'd8, 4'd4, 1'b0, 4'd4, 1'b0, 1'b0);
      op("ex_2m4", 4'd2, 4'd4, 1'b0, 4'd14, 1'b1, 1'b0);
      op("ex_0m0b", 4'd0, 4'd0, 1'b1, 4'd15, 1'b1, 1'b0);
      op("ex_15m15", 4'd15, 4'd15, 1'b0, 4'd0, 1'b0, 1'b0);
      op("ex_rep", 4'd7, 4'd2, 1'b0, 4'd5, 1'b0, 1'b1);
      repeat (3) @(negedge clk);
      chk("hold.diff", 32'(bus.diff), 5);
      chk("hold.done", 32'(bus.done), 0);
      @(negedge clk);
      bus.start = 1'b1;
      bus.a = 4'd7;
      bus.b = 4'd2;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1 chk_idle_zero("abort");
      dn = 0;
      repeat (6) begin
         @(negedge clk);
         dn += int'(bus.done);
      end
      chk("abort.ndone", 32'(dn), 0);
      rst_n = 1'b1;
      op("ex_9m3", 4'd9, 4'd3, 1'b0, 4'd6, 1'b0, 1'b0);
      for (int i = 0; i < 512; i++) begin
         r = 5'(i[7:4]) - 5'(i[3:0]) - 5'(i[8]);
         op("exh", 4'(i[7:4]), 4'(i[3:0]), i[8], r[3:0], r[4], 1'b0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
